// File: rtl/dcache_lookup_if.sv
// Request/response, flush, TLB-fill and refill-bus signals of the data cache.
// The slave modport is the cache. The master modport is the core together
// with the memory side, which drives the refill acknowledge and data.
interface dcache_lookup_if;
  logic        mem0_dc_read;
  logic        mem0_dc_trans;
  logic [8:0]  mem0_dc_asid;
  logic [29:0] mem0_dc_addr;
  logic        dc_flush;
  logic        tlb_fill_valid;
  logic [19:0] tlb_fill_vpn;
  logic [8:0]  tlb_fill_asid;
  logic [16:0] tlb_fill_ppn;
  logic        dc_valid;
  logic        dc_hit;
  logic [31:0] dc_data;
  logic        dc_tlb_miss;
  logic        dc_busy;
  logic        dc_bus_req;
  logic [26:0] dc_bus_addr;
  logic        dc_bus_ack;
  logic [31:0] dc_bus_rdata;

  modport slave (
    input  mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr,
    input  dc_flush, tlb_fill_valid, tlb_fill_vpn, tlb_fill_asid, tlb_fill_ppn,
    output dc_valid, dc_hit, dc_data, dc_tlb_miss, dc_busy,
    output dc_bus_req, dc_bus_addr,
    input  dc_bus_ack, dc_bus_rdata
  );

  modport master (
    output mem0_dc_read, mem0_dc_trans, mem0_dc_asid, mem0_dc_addr,
    output dc_flush, tlb_fill_valid, tlb_fill_vpn, tlb_fill_asid, tlb_fill_ppn,
    input  dc_valid, dc_hit, dc_data, dc_tlb_miss, dc_busy,
    input  dc_bus_req, dc_bus_addr,
    output dc_bus_ack, dc_bus_rdata
  );
endinterface

// File: rtl/dcache_lookup.sv
// Direct-mapped, read-only data cache with a one-cycle registered lookup and
// a word-serial line refill engine.
// Build option DCACHE_TLB_EN: when defined, translated requests go through a
// small fully-associative TLB. When undefined, translation is an identity
// map and dc_tlb_miss is always 0.
module dcache_lookup #(
  parameter int LINE_WORDS  = 4,
  parameter int SETS        = 64,
  parameter int TLB_ENTRIES = 4
) (
  input logic          clk_core,
  input logic          reset_n,
  dcache_lookup_if.slave dc
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 27 - OFF_W - IDX_W;
  localparam int LINE_W = 27 - OFF_W;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t               state_q, state_d;
  logic [SETS-1:0]      vld_q;
  logic [TAG_W-1:0]     tag_mem_q [SETS];
  logic [31:0]          mem_q [SETS*LINE_WORDS];

  logic                 dc_valid_q, dc_hit_q, dc_tlb_miss_q;
  logic [31:0]          dc_data_q;
  logic [LINE_W-1:0]    req_line_q;
  logic [LINE_W-1:0]    line_q;
  logic [OFF_W-1:0]     cnt_q;
  logic                 flush_pend_q;

  logic [26:0]          pa;
  logic                 tlb_miss;
  logic [OFF_W-1:0]     pa_off;
  logic [IDX_W-1:0]     pa_idx;
  logic [TAG_W-1:0]     pa_tag;
  logic                 lookup;
  logic                 hit_now;
  logic [31:0]          rd_word;
  logic                 refill_start, beat_wr, last_beat;
  logic [IDX_W-1:0]     req_idx, line_idx;
  logic [TAG_W-1:0]     line_tag;

`ifdef DCACHE_TLB_EN
  localparam int PTR_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  logic [TLB_ENTRIES-1:0] tlb_vld_q;
  logic [19:0]            tlb_vpn_q  [TLB_ENTRIES];
  logic [8:0]             tlb_asid_q [TLB_ENTRIES];
  logic [16:0]            tlb_ppn_q  [TLB_ENTRIES];
  logic [PTR_W-1:0]       tlb_ptr_q;
  logic                   tlb_hit;
  logic [16:0]            tlb_ppn;

  // TLB match (lowest matching entry wins) and physical address select
  always_comb begin
    tlb_hit  = 1'b0;
    tlb_ppn  = '0;
    pa       = dc.mem0_dc_addr[26:0];
    tlb_miss = 1'b0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_vld_q[i] && (tlb_vpn_q[i] == dc.mem0_dc_addr[29:10]) &&
          (tlb_asid_q[i] == dc.mem0_dc_asid)) begin
        tlb_hit = 1'b1;
        tlb_ppn = tlb_ppn_q[i];
      end
    end
    if (dc.mem0_dc_trans) begin
      pa       = {tlb_ppn, dc.mem0_dc_addr[9:0]};
      tlb_miss = ~tlb_hit;
    end
  end

  // TLB valid bits and round-robin fill pointer; flush beats a same-cycle fill
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      tlb_vld_q <= '0;
      tlb_ptr_q <= '0;
    end else if (dc.dc_flush) begin
      tlb_vld_q <= '0;
    end else if (dc.tlb_fill_valid) begin
      tlb_vld_q[tlb_ptr_q] <= 1'b1;
      tlb_ptr_q <= (tlb_ptr_q == PTR_W'(TLB_ENTRIES - 1)) ? '0 : tlb_ptr_q + PTR_W'(1);
    end
  end

  // TLB entry payload, written at the fill pointer
  always_ff @(posedge clk_core) begin
    if (dc.tlb_fill_valid && !dc.dc_flush) begin
      tlb_vpn_q[tlb_ptr_q]  <= dc.tlb_fill_vpn;
      tlb_asid_q[tlb_ptr_q] <= dc.tlb_fill_asid;
      tlb_ppn_q[tlb_ptr_q]  <= dc.tlb_fill_ppn;
    end
  end
`else
  logic unused_tlb;

  assign pa         = dc.mem0_dc_addr[26:0];
  assign tlb_miss   = 1'b0;
  assign unused_tlb = ^{dc.mem0_dc_trans, dc.mem0_dc_asid, dc.mem0_dc_addr[29:27],
                        dc.tlb_fill_valid, dc.tlb_fill_vpn, dc.tlb_fill_asid,
                        dc.tlb_fill_ppn, (TLB_ENTRIES > 0)};
`endif

  assign pa_off   = pa[OFF_W-1:0];
  assign pa_idx   = pa[OFF_W +: IDX_W];
  assign pa_tag   = pa[26 -: TAG_W];
  assign lookup   = dc.mem0_dc_read && (state_q == IDLE);
  assign rd_word  = mem_q[{pa_idx, pa_off}];
  assign hit_now  = lookup && !tlb_miss && vld_q[pa_idx] &&
                    (tag_mem_q[pa_idx] == pa_tag) && !dc.dc_flush;
  assign req_idx  = req_line_q[IDX_W-1:0];
  assign line_idx = line_q[IDX_W-1:0];
  assign line_tag = line_q[LINE_W-1:IDX_W];

  // ---- lookup stage -> registered response ----
  // Response registers; data reads as zero whenever the response is not a hit
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      dc_valid_q    <= 1'b0;
      dc_hit_q      <= 1'b0;
      dc_tlb_miss_q <= 1'b0;
      dc_data_q     <= '0;
    end else begin
      dc_valid_q    <= lookup;
      dc_hit_q      <= hit_now;
      dc_tlb_miss_q <= lookup && tlb_miss;
      dc_data_q     <= hit_now ? rd_word : '0;
    end
  end

  // Line address of the request, needed if the response turns out to be a miss
  always_ff @(posedge clk_core) begin
    if (lookup) req_line_q <= pa[26:OFF_W];
  end

  assign dc.dc_valid    = dc_valid_q;
  assign dc.dc_hit      = dc_hit_q;
  assign dc.dc_tlb_miss = dc_tlb_miss_q;
  assign dc.dc_data     = dc_data_q;

  // ---- response stage -> refill engine ----
  // Refill FSM next state and bus outputs
  always_comb begin
    state_d        = state_q;
    refill_start   = 1'b0;
    beat_wr        = 1'b0;
    last_beat      = 1'b0;
    dc.dc_busy     = 1'b0;
    dc.dc_bus_req  = 1'b0;
    dc.dc_bus_addr = '0;
    case (state_q)
      IDLE: begin
        if (dc_valid_q && !dc_hit_q && !dc_tlb_miss_q) begin
          state_d      = REFILL;
          refill_start = 1'b1;
        end
      end
      REFILL: begin
        dc.dc_busy     = 1'b1;
        dc.dc_bus_req  = 1'b1;
        dc.dc_bus_addr = {line_q, cnt_q};
        if (dc.dc_bus_ack) begin
          beat_wr = 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            last_beat = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_core) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Word counter and pending-flush flag for the line being refilled
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else if (refill_start) begin
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (beat_wr) cnt_q <= cnt_q + OFF_W'(1);
      if (dc.dc_flush && (state_q == REFILL)) flush_pend_q <= 1'b1;
    end
  end

  // Refill line address, captured when the miss is seen
  always_ff @(posedge clk_core) begin
    if (refill_start) line_q <= req_line_q;
  end

  // Line valid bits: cleared at refill start, set on the last beat unless flushed
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (dc.dc_flush) begin
      vld_q <= '0;
    end else begin
      if (refill_start) vld_q[req_idx] <= 1'b0;
      if (last_beat && !flush_pend_q) vld_q[line_idx] <= 1'b1;
    end
  end

  // Data and tag arrays written by the refill engine
  always_ff @(posedge clk_core) begin
    if (beat_wr)   mem_q[{line_idx, cnt_q}] <= dc.dc_bus_rdata;
    if (last_beat) tag_mem_q[line_idx]      <= line_tag;
  end

endmodule
